// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline controller.
// Stall/flush bus layout, FSM encodings and the per-cycle control payload.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W = 6;
  localparam int unsigned FLUSH_W = 4;
  localparam int unsigned STATE_W = 2;

  // Stall bus bit indices (1 = hold register)
  localparam int unsigned STALL_PC     = 0;
  localparam int unsigned STALL_IF_ID  = 1;
  localparam int unsigned STALL_ID_EX  = 2;
  localparam int unsigned STALL_EX_MEM = 3;
  localparam int unsigned STALL_MEM_WB = 4;
  localparam int unsigned STALL_RSVD   = 5;

  // Flush bus bit indices (1 = load bubble / write-disable)
  localparam int unsigned FLUSH_IF_ID  = 0;
  localparam int unsigned FLUSH_ID_EX  = 1;
  localparam int unsigned FLUSH_EX_MEM = 2;
  localparam int unsigned FLUSH_MEM_WB = 3;

  typedef enum logic [STATE_W-1:0] {
    CTRL_RUN  = 2'd0,
    CTRL_TRAP = 2'd1,
    CTRL_HALT = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic [STALL_W-1:0] stall;
    logic [FLUSH_W-1:0] flush;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_IDLE = '{stall: '0, flush: '0};

  // Hold every pipe register from pc up to and including stage idx.
  function automatic logic [STALL_W-1:0] hold_upto(input int unsigned idx);
    return STALL_W'((32'd1 << (idx + 32'd1)) - 32'd1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_wdt.sv
// Stall watchdog: counts consecutive stalled RUN cycles and flags the cycle
// on which the count would reach TIMEOUT. TIMEOUT of 0 disables it.
module pipe_ctrl_stall_wdt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic stalled,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Saturating run-length counter; any non-stalled or non-RUN cycle clears it
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en && stalled) begin
      if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign expired = (TIMEOUT != 0) && en && stalled && (cnt == CNT_LAST);

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stage stall requests and branch
// redirects, sequences 2-cycle exception entry, and halts on a stuck stall.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_if_i,
  input  logic                stallreq_id_i,
  input  logic                stallreq_ex_i,
  input  logic                stallreq_mem_i,
  input  logic                branch_flag_i,
  input  logic [XLEN-1:0]     branch_target_i,
  input  logic                excp_req_i,
  input  logic [XLEN-1:0]     excp_vec_i,
  output logic [STALL_W-1:0]  stall_o,
  output logic [FLUSH_W-1:0]  flush_o,
  output logic                redirect_o,
  output logic [XLEN-1:0]     redirect_pc_o,
  output logic                timeout_o,
  output logic [STATE_W-1:0]  state_o
);

  ctrl_state_e     state_q;
  ctrl_state_e     state_d;
  logic [XLEN-1:0] vec_q;

  pipe_ctl_t       ctl_c;
  logic            redirect_c;
  logic [XLEN-1:0] redirect_pc_c;
  logic            vec_load_c;
  logic            run_c;
  logic            run_stalled_c;
  logic            wdt_expired;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= CTRL_RUN;
    else      state_q <= state_d;
  end

  // Trap vector captured when the exception is accepted
  always_ff @(posedge clk) begin
    if (!rst)            vec_q <= '0;
    else if (vec_load_c) vec_q <= excp_vec_i;
  end

  // Equivalent to |stall_o[4:0] in RUN, derived from inputs to keep the
  // watchdog off the output mux path.
  assign run_c         = (state_q == CTRL_RUN);
  assign run_stalled_c = !excp_req_i &&
                         (stallreq_mem_i || stallreq_ex_i ||
                          (!branch_flag_i && (stallreq_id_i || stallreq_if_i)));

  pipe_ctrl_stall_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk     (clk),
    .rst     (rst),
    .en      (run_c),
    .stalled (run_stalled_c),
    .expired (wdt_expired)
  );

  // Next-state and priority mux
  always_comb begin
    state_d       = state_q;
    ctl_c         = CTL_IDLE;
    redirect_c    = 1'b0;
    redirect_pc_c = '0;
    vec_load_c    = 1'b0;

    unique case (state_q)
      CTRL_RUN: begin
        if (excp_req_i) begin
          ctl_c.flush = '1;
        end else if (stallreq_mem_i) begin
          ctl_c.stall = hold_upto(STALL_MEM_WB);
        end else if (stallreq_ex_i) begin
          // Any coincident branch is held in EX and re-presented later
          ctl_c.stall               = hold_upto(STALL_EX_MEM);
          ctl_c.flush[FLUSH_EX_MEM] = 1'b1;
        end else if (branch_flag_i) begin
          // Branch flushes the younger instrs, so id/if stalls are moot
          redirect_c               = 1'b1;
          redirect_pc_c            = branch_target_i;
          ctl_c.flush[FLUSH_IF_ID] = 1'b1;
          ctl_c.flush[FLUSH_ID_EX] = 1'b1;
        end else if (stallreq_id_i) begin
          ctl_c.stall              = hold_upto(STALL_ID_EX);
          ctl_c.flush[FLUSH_ID_EX] = 1'b1;
        end else if (stallreq_if_i) begin
          ctl_c.stall              = hold_upto(STALL_IF_ID);
          ctl_c.flush[FLUSH_IF_ID] = 1'b1;
        end

        if (excp_req_i) begin
          vec_load_c = 1'b1;
          state_d    = CTRL_TRAP;
        end else if (wdt_expired) begin
          state_d = CTRL_HALT;
        end
      end

      CTRL_TRAP: begin
        redirect_c               = 1'b1;
        redirect_pc_c            = vec_q;
        ctl_c.flush[FLUSH_IF_ID] = 1'b1;
        state_d                  = CTRL_RUN;
      end

      CTRL_HALT: begin
        ctl_c.stall = '1;
      end

      default: begin
        state_d = CTRL_RUN;
      end
    endcase

    // Reset holds the pipe empty and quiet regardless of state
    if (!rst) begin
      ctl_c.stall   = '0;
      ctl_c.flush   = '1;
      redirect_c    = 1'b0;
      redirect_pc_c = '0;
      vec_load_c    = 1'b0;
    end
  end

  assign stall_o       = ctl_c.stall;
  assign flush_o       = ctl_c.flush;
  assign redirect_o    = redirect_c;
  assign redirect_pc_o = redirect_pc_c;
  assign timeout_o     = rst && (state_q == CTRL_HALT);
  assign state_o       = state_q;

endmodule
